// File: rtl/oled_spi_driver.sv
// rtl/oled_spi_driver.sv - Pmod OLED power-up sequencer and SPI mode-3 byte shifter
//
// Purpose:
//   Runs the panel power-up sequence after reset, then accepts bytes over a
//   valid/ready handshake. Each byte goes out MSB-first on SDIN/SCLK, and DC
//   qualifies each byte as display data or a command.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   cmdValid   in   CPU offers a byte
//   cmdData    in   byte to send
//   cmdIsData  in   1 = display data (DC=1), 0 = command (DC=0)
//   cmdReady   out  byte is accepted on any edge where cmdValid is also high
//   initDone   out  power-up complete, sticky until rst
//   SDIN       out  serial data, changes only on SCLK falling edges
//   SCLK       out  serial clock, idle high
//   DC         out  data/command select, held until the next accepted byte
//   RES        out  panel reset, active-low
//   VBAT       out  panel VBAT enable, active-low
//   VDD        out  panel logic-supply enable, active-low

module oled_spi_driver #(
    parameter int CLK_DIV        = 4,
    parameter int PWR_DELAY      = 8,
    parameter int RES_LOW_CYCLES = 16,
    parameter int VBAT_DELAY     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmdValid,
    input  logic [7:0] cmdData,
    input  logic       cmdIsData,
    output logic       cmdReady,
    output logic       initDone,
    output logic       SDIN,
    output logic       SCLK,
    output logic       DC,
    output logic       RES,
    output logic       VBAT,
    output logic       VDD
);

    localparam logic [2:0] S_P_VDD   = 3'd0;
    localparam logic [2:0] S_P_RESLO = 3'd1;
    localparam logic [2:0] S_P_RESHI = 3'd2;
    localparam logic [2:0] S_P_VBAT  = 3'd3;
    localparam logic [2:0] S_IDLE    = 3'd4;
    localparam logic [2:0] S_SHIFT   = 3'd5;

    localparam int MAX_A   = (PWR_DELAY > RES_LOW_CYCLES) ? PWR_DELAY : RES_LOW_CYCLES;
    localparam int MAX_DLY = (MAX_A > VBAT_DELAY) ? MAX_A : VBAT_DELAY;
    // Holds the full PWR_DELAY value that is loaded at reset, not just delay-1.
    localparam int CNT_W   = $clog2(MAX_DLY + 1);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_PWR  = CNT_W'(PWR_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_RES  = CNT_W'(RES_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_VBAT = CNT_W'(VBAT_DELAY - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [2:0]       bit_q,    bit_d;
    logic [7:0]       shreg_q,  shreg_d;
    logic             ready_q,  ready_d;
    logic             init_q,   init_d;
    logic             sdin_q,   sdin_d;
    logic             sclk_q,   sclk_d;
    logic             dc_q,     dc_d;
    logic             res_q,    res_d;
    logic             vbat_q,   vbat_d;
    logic             vdd_q,    vdd_d;

    // Each power state is entered on the edge that changes its output. The
    // counter is loaded with duration-1 on entry, and the state is left when
    // the counter reads zero. The reset load of the full PWR_DELAY covers the
    // extra first edge, on which VDD switches on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        init_d  = init_q;
        sdin_d  = sdin_q;
        sclk_d  = sclk_q;
        dc_d    = dc_q;
        res_d   = res_q;
        vbat_d  = vbat_q;
        vdd_d   = vdd_q;

        case (state_q)
            S_P_VDD: begin
                vdd_d = 1'b0;
                if (cnt_q == '0) begin
                    res_d   = 1'b0;
                    cnt_d   = CNT_RES;
                    state_d = S_P_RESLO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_P_RESLO: begin
                if (cnt_q == '0) begin
                    res_d   = 1'b1;
                    cnt_d   = CNT_PWR;
                    state_d = S_P_RESHI;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_P_RESHI: begin
                if (cnt_q == '0) begin
                    vbat_d  = 1'b0;
                    cnt_d   = CNT_VBAT;
                    state_d = S_P_VBAT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_P_VBAT: begin
                if (cnt_q == '0) begin
                    init_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (cmdValid && ready_q) begin
                    shreg_d = cmdData;
                    dc_d    = cmdIsData;
                    sdin_d  = cmdData[7];
                    sclk_d  = 1'b0;
                    ready_d = 1'b0;
                    bit_d   = 3'd7;
                    div_d   = DIV_LOAD;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    div_d  = DIV_LOAD;
                end else if (bit_q == 3'd0) begin
                    // End of the high half of bit0. SDIN is left holding bit0.
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // shreg_q[7] is the bit on the line now, so the next bit
                    // out is shreg_q[6].
                    sclk_d  = 1'b0;
                    sdin_d  = shreg_q[6];
                    shreg_d = {shreg_q[6:0], 1'b0};
                    bit_d   = bit_q - 3'd1;
                    div_d   = DIV_LOAD;
                end
            end
            default: begin
                state_d = S_P_VDD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_P_VDD;
            cnt_q   <= CNT_W'(PWR_DELAY);
            div_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            ready_q <= 1'b0;
            init_q  <= 1'b0;
            sdin_q  <= 1'b0;
            sclk_q  <= 1'b1;
            dc_q    <= 1'b0;
            res_q   <= 1'b1;
            vbat_q  <= 1'b1;
            vdd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            init_q  <= init_d;
            sdin_q  <= sdin_d;
            sclk_q  <= sclk_d;
            dc_q    <= dc_d;
            res_q   <= res_d;
            vbat_q  <= vbat_d;
            vdd_q   <= vdd_d;
        end
    end

    assign cmdReady = ready_q;
    assign initDone = init_q;
    assign SDIN     = sdin_q;
    assign SCLK     = sclk_q;
    assign DC       = dc_q;
    assign RES      = res_q;
    assign VBAT     = vbat_q;
    assign VDD      = vdd_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// tb/tb_oled_spi_driver.sv - directed self-checking bench for oled_spi_driver

module tb_oled_spi_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmdValid, cmdIsData;
    logic [7:0] cmdData;
    logic       cmdReady, initDone, SDIN, SCLK, DC, RES, VBAT, VDD;

    logic       valid1, isdata1;
    logic [7:0] data1;
    logic       ready1, init1, sdin1, sclk1, dc1, res1, vbat1, vdd1;

    logic       sel;
    logic       m_sclk, m_sdin, m_dc, m_ready;
    logic [7:0] rx;
    int         rx_n;
    int         cyc;
    int         n_checks, n_errors;

    always #5 clk = ~clk;

    oled_spi_driver u_dut (
        .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdData(cmdData),
        .cmdIsData(cmdIsData), .cmdReady(cmdReady), .initDone(initDone),
        .SDIN(SDIN), .SCLK(SCLK), .DC(DC), .RES(RES), .VBAT(VBAT), .VDD(VDD)
    );

    oled_spi_driver #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmdValid(valid1), .cmdData(data1),
        .cmdIsData(isdata1), .cmdReady(ready1), .initDone(init1),
        .SDIN(sdin1), .SCLK(sclk1), .DC(dc1), .RES(res1), .VBAT(vbat1), .VDD(vdd1)
    );

    assign m_sclk  = sel ? sclk1  : SCLK;
    assign m_sdin  = sel ? sdin1  : SDIN;
    assign m_dc    = sel ? dc1    : DC;
    assign m_ready = sel ? ready1 : cmdReady;

    initial begin
        cyc  = 0;
        rx   = 8'h00;
        rx_n = 0;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Panel's view: capture SDIN on every SCLK rising edge.
    always @(posedge m_sclk) begin
        rx   = {rx[6:0], m_sdin};
        rx_n = rx_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Releases rst; the next rising edge is E. Samples after edges E+0..E+64.
    task automatic powerup(input string tag);
        logic [5:0] exp;
        rst = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            exp = {1'b0,
                   !(k >= 8 && k <= 23),
                   !(k >= 32),
                   (k >= 64),
                   (k >= 64),
                   1'b1};
            check($sformatf("%s k=%0d", tag, k),
                  {26'd0, VDD, RES, VBAT, initDone, cmdReady, SCLK}, {26'd0, exp});
        end
    endtask

    // Called on a falling clk edge with ready=1 and valid=1, so the next
    // rising edge accepts the byte.
    task automatic watch(input string tag, input logic [7:0] exp_b, input logic exp_dc,
                         input int cd, input int chg_at, input logic [7:0] chg_val,
                         output int first_fall);
        int n, low, rx_base;
        n = 0;
        low = 0;
        rx_base = rx_n;
        first_fall = -1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                first_fall = cyc;
                check({tag, " sclk_fall"}, m_sclk, 1'b0);
            end
            if (n == chg_at) cmdData = chg_val;
            check({tag, " dc"}, m_dc, exp_dc);
            if (!m_ready) low++;
        end while (!m_ready && n < 400);
        check({tag, " ready_low"}, low, 16 * cd);
        check({tag, " rises"}, rx_n - rx_base, 8);
        check({tag, " bits"}, rx, exp_b);
        check({tag, " sclk_end"}, m_sclk, 1'b1);
        check({tag, " sdin_end"}, m_sdin, exp_b[0]);
    endtask

    initial begin
        int f1, f2;
        n_checks  = 0;
        n_errors  = 0;
        sel       = 1'b0;
        rst       = 1'b1;
        cmdValid  = 1'b1;
        cmdData   = 8'hA5;
        cmdIsData = 1'b0;
        valid1    = 1'b0;
        data1     = 8'h00;
        isdata1   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset", {SCLK, SDIN, DC, RES, VBAT, VDD, cmdReady, initDone}, 8'b1001_1100);

        powerup("pwr1");
        watch("a5", 8'hA5, 1'b0, 4, -1, 8'h00, f1);

        cmdData = 8'h3C; cmdIsData = 1'b1;
        watch("3c", 8'h3C, 1'b1, 4, -1, 8'h00, f1);
        cmdData = 8'h81; cmdIsData = 1'b0;
        watch("81", 8'h81, 1'b0, 4, -1, 8'h00, f2);
        check("b2b_gap", f2 - f1, 65);

        cmdData = 8'hFF; cmdIsData = 1'b1;
        watch("ff_chg", 8'hFF, 1'b1, 4, 10, 8'h00, f1);

        // Byte 0xFF with valid held; reset lands in the low half of bit 3.
        cmdData = 8'hFF; cmdIsData = 1'b1;
        repeat (34) @(negedge clk);
        check("pre_rst_sdin", SDIN, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {SCLK, SDIN, DC, RES, VBAT, VDD, cmdReady, initDone}, 8'b1001_1100);
        repeat (2) @(negedge clk);
        cmdData = 8'hA5; cmdIsData = 1'b0;
        powerup("pwr2");
        watch("a5_again", 8'hA5, 1'b0, 4, -1, 8'h00, f1);
        cmdValid = 1'b0;

        check("cd1_ready", {ready1, init1}, 2'b11);
        sel = 1'b1;
        data1 = 8'h5A; isdata1 = 1'b0; valid1 = 1'b1;
        watch("cd1_5a", 8'h5A, 1'b0, 1, -1, 8'h00, f1);
        data1 = 8'hC3; isdata1 = 1'b1;
        watch("cd1_c3", 8'hC3, 1'b1, 1, -1, 8'h00, f2);
        valid1 = 1'b0;
        check("cd1_gap", f2 - f1, 17);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
